// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - decode/execute interlock: RAW scoreboard, redirect flush, halt drain, stall counter
module id_hazard_ctrl #(
    parameter int WB_DIST = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_p1,
    input  logic [2:0]       rs_p1,
    input  logic [2:0]       rt_p1,
    input  logic             rs_used_p1,
    input  logic             rt_used_p1,
    input  logic             rd_wr_p1,
    input  logic [2:0]       rd_p1,
    input  logic             halt_p1,
    input  logic             redirect_ix_p1,
    input  logic             mem_stall_p1,
    output logic             issue_ix_p1,
    output logic             bubble_ix_p1,
    output logic             stall_if_p1,
    output logic             flush_ifid_p1,
    output logic             halted_p1,
    output logic [CNT_W-1:0] hazard_cnt_p1
);

    localparam logic [1:0] WB_VAL = 2'(WB_DIST);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q [8];
    logic [1:0]       cnt_d [8];
    logic [7:0]       busy;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             hazard;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            busy[i] = (cnt_q[i] != 2'd0);
        end
    end

    // Checked against pre-issue counts only, so rs==rd never blocks itself.
    assign hazard = id_valid_p1 & ((rs_used_p1 & busy[rs_p1]) | (rt_used_p1 & busy[rt_p1]));

    always_comb begin
        issue_ix_p1   = 1'b0;
        bubble_ix_p1  = 1'b0;
        stall_if_p1   = 1'b0;
        flush_ifid_p1 = 1'b0;
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (mem_stall_p1) begin
            stall_if_p1 = 1'b1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                cnt_d[i] = busy[i] ? cnt_q[i] - 2'd1 : 2'd0;
            end
            if (redirect_ix_p1) begin
                flush_ifid_p1 = 1'b1;
                bubble_ix_p1  = 1'b1;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (hazard) begin
                            stall_if_p1  = 1'b1;
                            bubble_ix_p1 = 1'b1;
                            if (hcnt_q != {CNT_W{1'b1}}) begin
                                hcnt_d = hcnt_q + 1'b1;
                            end
                        end else if (id_valid_p1) begin
                            issue_ix_p1 = 1'b1;
                            // Reload overrides the same-cycle decrement on rd.
                            if (rd_wr_p1) begin
                                cnt_d[rd_p1] = WB_VAL;
                            end
                            if (halt_p1) begin
                                state_d = ST_DRAIN;
                            end
                        end else begin
                            bubble_ix_p1 = 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        stall_if_p1  = 1'b1;
                        bubble_ix_p1 = 1'b1;
                        if (busy == 8'd0) begin
                            state_d = ST_HALTED;
                        end
                    end
                    default: begin
                        stall_if_p1  = 1'b1;
                        bubble_ix_p1 = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            hcnt_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign halted_p1     = (state_q == ST_HALTED);
    assign hazard_cnt_p1 = hcnt_q;

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

In-order interlock and pipeline sequencing controller between decode and execute. It keeps a per-register scoreboard of in-flight writes and stalls IF/ID on read-after-write hazards. It kills the ID instruction and flushes IF/ID on an IX redirect. It drains the pipe and holds the core stopped after HALT issues, and it counts hazard stall cycles.

## Interface
Parameters:
- WB_DIST, 2, cycles after issue during which the destination register is not yet readable in ID (legal 1..3).
- CNT_W, 16, width of hazard stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- id_valid_p1  in  1  ID holds a valid instruction.
- rs_p1  in  3  source register.
- rt_p1  in  3  second source register.
- rs_used_p1  in  1  instruction reads rs.
- rt_used_p1  in  1  instruction reads rt.
- rd_wr_p1  in  1  instruction writes a register. JAL/JALR drive rd_p1=7.
- rd_p1  in  3  destination register.
- halt_p1  in  1  ID instruction is HALT.
- redirect_ix_p1  in  1  branch/jump in IX changes PC this cycle.
- mem_stall_p1  in  1  memory not ready; whole pipe frozen.
- issue_ix_p1  out  1  ID instruction advances into IX this cycle.
- bubble_ix_p1  out  1  IX loads a bubble this cycle.
- stall_if_p1  out  1  hold PC and IF/ID.
- flush_ifid_p1  out  1  invalidate IF/ID.
- halted_p1  out  1  core stopped.
- hazard_cnt_p1  out  CNT_W  saturating count of RAW stall cycles.

## Operation
- Scoreboard: cnt[0..7], 2 bits each. Register r is busy iff cnt[r] != 0.
- hazard = id_valid & ((rs_used & busy[rs]) | (rt_used & busy[rt])).
- Priority per cycle is mem_stall > redirect > state-based blocking > hazard > issue.
- mem_stall=1:
  - stall_if=1; issue=0; bubble=0.
  - Scoreboard, state and counter are frozen.
  - flush is held off even if redirect=1; redirect is re-sampled next cycle.
- redirect=1 without mem_stall:
  - flush_ifid=1; issue=0; bubble=1; stall_if=0.
  - The ID instruction is killed, including a HALT: no scoreboard set, no state change.
- In state RUN, with no redirect and no mem_stall:
  - hazard: stall_if=1, bubble=1, issue=0, and hazard_cnt increments, saturating at all-ones.
  - Otherwise, if id_valid: issue=1.
  - If an issuing instruction has rd_wr, it loads cnt[rd]=WB_DIST.
  - If an issuing instruction has halt: next state is DRAIN.
  - If id_valid=0: bubble=1.
- FSM states:
  - RUN: normal operation.
  - DRAIN: stall_if=1, bubble=1, issue=0. Go to HALTED when all cnt == 0, evaluated on registered values.
  - HALTED: halted=1, stall_if=1, bubble=1. Terminal until rst.
- Scoreboard update on every non-mem_stall edge:
  - Each nonzero cnt decrements.
  - An issuing write sets its cnt to WB_DIST, overriding the decrement on the same register.
  - Write with rd equal to a busy register: the reload wins.
  - Self-dependency (rs==rd, e.g. ADDI r1,r1): hazard is checked on the pre-issue cnt only.
- No forwarding is assumed. The register file is write-before-read, so cnt reaching 0 means the value is readable in ID.

## Timing
- All outputs except the registered ones are combinational from the registered state and the current inputs. The registered outputs are halted_p1 and hazard_cnt_p1.
- Scoreboard, FSM and counter update on the rising clk edge.
- Issue at cycle t of a writer to rX:
  - A dependent read is stalled in cycles t+1..t+WB_DIST.
  - The dependent can issue at t+WB_DIST+1.
  - mem_stall cycles in between extend this 1:1.
- HALT issued at cycle t with the scoreboard empty afterwards: DRAIN at t+1, HALTED (halted_p1=1) at t+2.
- Reset, asserted any time: cnt all 0, state RUN, halted_p1=0, hazard_cnt_p1=0.
- Reset outputs with id_valid=0 and no mem_stall or redirect: issue=0, bubble=1, stall_if=0, flush=0.
- Reset during DRAIN/HALTED returns to RUN immediately; the pending scoreboard is discarded.

## Test plan
- ADD r1 issue cycle 0 (rd_wr, rd=1), then cycle 1 SUB reading rs=1 -> stall_if/bubble=1 cycles 1–2, issue=1 cycle 3, hazard_cnt=2.
- Same as above, with mem_stall=1 in cycle 2 -> issue moves to cycle 4; hazard_cnt=2; cycle 2 shows bubble=0, issue=0.
- Dependent in ID with busy rs and redirect_ix=1 same cycle -> flush=1, bubble=1, stall_if=0, hazard_cnt unchanged; ID write does not set the scoreboard.
- LD r3 issues, then HALT issues next cycle -> DRAIN; halted=1 exactly when cnt[3] reaches 0 plus one cycle; stays 1; rst async clears to RUN with halted=0 without a clock edge.
- HALT in ID with redirect=1 -> not issued, state stays RUN, halted stays 0.
- rt_used=0 with busy rt; rd==rs busy reload; force hazard for 2^CNT_W+2 cycles (CNT_W=4) -> no stall on rt; cnt reloads to WB_DIST; counter saturates at 15.
